rv_dmem_wb_bridge: RTL and testbench



---
 rtl/rv_bus_pkg.sv | 21 ++
 rtl/rv_bus_timeout.sv | 26 ++
 rtl/rv_dmem_wb_bridge.sv | 150 +++++++++++++++
 tb/tb_rv_dmem_wb_bridge.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_bus_pkg.sv
// Shared definitions for the core's Wishbone bus bridges (data and instruction side):
// FSM state encoding, default error data, bus width constants and timeout sizing.
package rv_bus_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } bus_state_e;

  localparam int WB_ADR_W = 32;
  localparam int WB_SEL_W = 4;
  localparam int WB_DAT_W = 32;

  localparam logic [WB_DAT_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Narrowest supported watchdog width (8 or 16 bits) that can hold the limit.
  function automatic int timeout_width(input int cycles);
    return (cycles > 255) ? 16 : 8;
  endfunction

endpackage

// File: rtl/rv_bus_timeout.sv
// Clear/enable/limit watchdog counter; expire is high in the cycle whose count
// increment would reach the limit, so the bus cycle ends after exactly `limit` cycles.
module rv_bus_timeout #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expire
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign expire = enable && (count_q == (limit - WIDTH'(1)));

endmodule

// File: rtl/rv_dmem_wb_bridge.sv
// Data-memory responder that turns one core load/store into one Wishbone classic cycle.
// Optional bus watchdog enabled by defining RV_DMEM_WB_TIMEOUT_EN.
module rv_dmem_wb_bridge
  import rv_bus_pkg::*;
#(
  parameter int                   g_timeout_cycles = 255,
  parameter logic [WB_DAT_W-1:0]  g_err_data       = ERR_DATA_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [WB_ADR_W-1:0] dm_addr_i,
  input  logic [WB_DAT_W-1:0] dm_data_s_i,
  input  logic [WB_SEL_W-1:0] dm_data_select_i,
  input  logic                dm_load_i,
  input  logic                dm_store_i,
  output logic                dm_ready_o,
  output logic [WB_DAT_W-1:0] dm_data_l_o,
  output logic                dm_load_done_o,
  output logic                dm_store_done_o,
  output logic                dm_bus_err_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [WB_SEL_W-1:0] wb_sel_o,
  output logic [WB_ADR_W-1:0] wb_adr_o,
  output logic [WB_DAT_W-1:0] wb_dat_o,
  input  logic [WB_DAT_W-1:0] wb_dat_i,
  input  logic                wb_ack_i,
  input  logic                wb_err_i
);

  bus_state_e state_q, state_d;
  logic       accept;
  logic       finish_ok;
  logic       finish_err;
  logic       timeout_hit;
  logic       unused_ok;

  if (g_timeout_cycles < 1 || g_timeout_cycles > 65535) begin : g_bad_timeout
    $error("rv_dmem_wb_bridge: g_timeout_cycles must be in 1..65535");
  end

  // Byte offset is carried by the lane selects; the bus only sees word addresses.
  assign unused_ok = ^dm_addr_i[1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    finish_ok  = 1'b0;
    finish_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dm_load_i || dm_store_i) begin
          accept  = 1'b1;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        // Error (or watchdog) outranks ack when both land in the same cycle.
        if (wb_err_i || timeout_hit) begin
          finish_err = 1'b1;
          state_d    = ST_IDLE;
        end else if (wb_ack_i) begin
          finish_ok = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef RV_DMEM_WB_TIMEOUT_EN
  localparam int TO_W = timeout_width(g_timeout_cycles);

  rv_bus_timeout #(
    .WIDTH (TO_W)
  ) u_timeout (
    .clk    (clk_i),
    .rst    (rst_i),
    .clear  (accept),
    .enable ((state_q == ST_BUS) && !wb_ack_i && !wb_err_i),
    .limit  (TO_W'(g_timeout_cycles)),
    .expire (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Store wins over load when both strobes arrive together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_cyc_o        <= 1'b0;
      wb_stb_o        <= 1'b0;
      wb_we_o         <= 1'b0;
      wb_sel_o        <= '0;
      wb_adr_o        <= '0;
      wb_dat_o        <= '0;
      dm_data_l_o     <= '0;
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      dm_bus_err_o    <= 1'b0;
    end else begin
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      dm_bus_err_o    <= 1'b0;
      if (accept) begin
        wb_adr_o <= {dm_addr_i[WB_ADR_W-1:2], 2'b00};
        wb_sel_o <= dm_data_select_i;
        wb_dat_o <= dm_data_s_i;
        wb_we_o  <= dm_store_i;
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
      end else if (finish_ok || finish_err) begin
        wb_cyc_o     <= 1'b0;
        wb_stb_o     <= 1'b0;
        dm_bus_err_o <= finish_err;
        if (wb_we_o) begin
          dm_store_done_o <= 1'b1;
        end else begin
          dm_load_done_o <= 1'b1;
          dm_data_l_o    <= finish_err ? g_err_data : wb_dat_i;
        end
      end
    end
  end

  assign dm_ready_o = (state_q == ST_IDLE);

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(dm_load_i && dm_store_i))
        else $error("rv_dmem_wb_bridge: load and store requested together");
      assert (dm_ready_o || !(dm_load_i || dm_store_i))
        else $error("rv_dmem_wb_bridge: request while not ready");
    end
  end
`endif

endmodule

// File: tb/tb_rv_dmem_wb_bridge.sv
// Directed self-checking bench for rv_dmem_wb_bridge; the watchdog scenario follows
// RV_DMEM_WB_TIMEOUT_EN so the same bench covers both builds.
module tb_rv_dmem_wb_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_data_s_i;
  logic [3:0]  dm_data_select_i;
  logic        dm_load_i;
  logic        dm_store_i;
  logic        dm_ready_o;
  logic [31:0] dm_data_l_o;
  logic        dm_load_done_o;
  logic        dm_store_done_o;
  logic        dm_bus_err_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  int tests_run    = 0;
  int tests_failed = 0;

  rv_dmem_wb_bridge #(
    .g_timeout_cycles (4),
    .g_err_data       (32'hDEAD_BEEF)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .dm_addr_i        (dm_addr_i),
    .dm_data_s_i      (dm_data_s_i),
    .dm_data_select_i (dm_data_select_i),
    .dm_load_i        (dm_load_i),
    .dm_store_i       (dm_store_i),
    .dm_ready_o       (dm_ready_o),
    .dm_data_l_o      (dm_data_l_o),
    .dm_load_done_o   (dm_load_done_o),
    .dm_store_done_o  (dm_store_done_o),
    .dm_bus_err_o     (dm_bus_err_o),
    .wb_cyc_o         (wb_cyc_o),
    .wb_stb_o         (wb_stb_o),
    .wb_we_o          (wb_we_o),
    .wb_sel_o         (wb_sel_o),
    .wb_adr_o         (wb_adr_o),
    .wb_dat_o         (wb_dat_o),
    .wb_dat_i         (wb_dat_i),
    .wb_ack_i         (wb_ack_i),
    .wb_err_i         (wb_err_i)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
      else begin
        tests_failed++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  task automatic apply_stimulus(input logic load, input logic store,
                                input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] sel);
    dm_load_i        = load;
    dm_store_i       = store;
    dm_addr_i        = addr;
    dm_data_s_i      = data;
    dm_data_select_i = sel;
  endtask

  task automatic check_idle_done(input string tag, input logic ld, input logic st,
                                 input logic err);
    check_output({tag, " load_done"},  32'(dm_load_done_o),  32'(ld));
    check_output({tag, " store_done"}, 32'(dm_store_done_o), 32'(st));
    check_output({tag, " bus_err"},    32'(dm_bus_err_o),    32'(err));
    check_output({tag, " cyc"},        32'(wb_cyc_o),        32'd0);
    check_output({tag, " ready"},      32'(dm_ready_o),      32'd1);
  endtask

  initial begin
    rst_i    = 1'b1;
    wb_dat_i = '0;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    step();

    check_output("rst ready", 32'(dm_ready_o), 32'd1);
    check_output("rst cyc",   32'(wb_cyc_o),   32'd0);
    check_output("rst stb",   32'(wb_stb_o),   32'd0);
    check_output("rst we",    32'(wb_we_o),    32'd0);
    check_output("rst sel",   32'(wb_sel_o),   32'd0);
    check_output("rst adr",   wb_adr_o,        32'd0);
    check_output("rst dat",   wb_dat_o,        32'd0);
    check_output("rst data_l", dm_data_l_o,    32'd0);
    check_idle_done("rst", 1'b0, 1'b0, 1'b0);
    rst_i = 1'b0;
    step();

    // Load, zero wait states.
    apply_stimulus(1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'hF);
    step();
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check_output("ld0 cyc",   32'(wb_cyc_o),   32'd1);
    check_output("ld0 stb",   32'(wb_stb_o),   32'd1);
    check_output("ld0 adr",   wb_adr_o,        32'h0000_1004);
    check_output("ld0 we",    32'(wb_we_o),    32'd0);
    check_output("ld0 sel",   32'(wb_sel_o),   32'hF);
    check_output("ld0 ready", 32'(dm_ready_o), 32'd0);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h1234_5678;
    step();
    wb_ack_i = 1'b0;
    wb_dat_i = 32'h0;
    check_idle_done("ld0 done", 1'b1, 1'b0, 1'b0);
    check_output("ld0 data", dm_data_l_o, 32'h1234_5678);
    step();
    check_output("ld0 pulse end", 32'(dm_load_done_o), 32'd0);
    check_output("ld0 data hold", dm_data_l_o, 32'h1234_5678);

    // Byte store with three wait states.
    apply_stimulus(1'b0, 1'b1, 32'h0000_2003, 32'hAAAA_AAAA, 4'b1000);
    step();
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("st3 cyc w%0d", i), 32'(wb_cyc_o), 32'd1);
      check_output($sformatf("st3 adr w%0d", i), wb_adr_o,      32'h0000_2000);
      check_output($sformatf("st3 sel w%0d", i), 32'(wb_sel_o), 32'b1000);
      check_output($sformatf("st3 we w%0d", i),  32'(wb_we_o),  32'd1);
      check_output($sformatf("st3 dat w%0d", i), wb_dat_o,      32'hAAAA_AAAA);
      check_output($sformatf("st3 done w%0d", i), 32'(dm_store_done_o), 32'd0);
      if (i == 3) wb_ack_i = 1'b1;
      step();
    end
    wb_ack_i = 1'b0;
    check_idle_done("st3 done", 1'b0, 1'b1, 1'b0);
    check_output("st3 data_l untouched", dm_data_l_o, 32'h1234_5678);
    step();

    // Load terminated by bus error on the second bus cycle.
    apply_stimulus(1'b1, 1'b0, 32'h0000_3008, 32'h0, 4'hF);
    step();
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    check_output("err cyc2", 32'(wb_cyc_o), 32'd1);
    wb_err_i = 1'b1;
    wb_dat_i = 32'h5555_5555;
    step();
    wb_err_i = 1'b0;
    check_idle_done("err done", 1'b1, 1'b0, 1'b1);
    check_output("err data", dm_data_l_o, 32'hDEAD_BEEF);
    step();
    check_output("err flag clears", 32'(dm_bus_err_o), 32'd0);

    // Back-to-back: load accepted in the store's done cycle.
    apply_stimulus(1'b0, 1'b1, 32'h0000_4000, 32'h0000_0055, 4'hF);
    step();
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    wb_ack_i = 1'b1;
    step();
    wb_ack_i = 1'b0;
    check_idle_done("b2b store", 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0, 32'h0000_4006, 32'h0, 4'b1100);
    step();
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check_output("b2b cyc", 32'(wb_cyc_o), 32'd1);
    check_output("b2b adr", wb_adr_o, 32'h0000_4004);
    check_output("b2b we",  32'(wb_we_o), 32'd0);
    check_output("b2b sel", 32'(wb_sel_o), 32'b1100);
    check_output("b2b store pulse end", 32'(dm_store_done_o), 32'd0);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hCAFE_F00D;
    step();
    wb_ack_i = 1'b0;
    check_idle_done("b2b load", 1'b1, 1'b0, 1'b0);
    check_output("b2b data", dm_data_l_o, 32'hCAFE_F00D);
    step();

    // Ack and err together on a store: err wins.
    apply_stimulus(1'b0, 1'b1, 32'h0000_5000, 32'h0101_0101, 4'h1);
    step();
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    wb_ack_i = 1'b1;
    wb_err_i = 1'b1;
    step();
    wb_err_i = 1'b0;
    check_idle_done("ackerr", 1'b0, 1'b1, 1'b1);
    // ack remains high into IDLE and must be ignored.
    step();
    wb_ack_i = 1'b0;
    check_idle_done("idle ack", 1'b0, 1'b0, 1'b0);
    check_output("idle ack data", dm_data_l_o, 32'hCAFE_F00D);

    // Reset two cycles into BUS abandons the cycle without a done pulse.
    apply_stimulus(1'b1, 1'b0, 32'h0000_6000, 32'h0, 4'hF);
    step();
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    check_output("rstbus cyc before", 32'(wb_cyc_o), 32'd1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check_output("rstbus stb", 32'(wb_stb_o), 32'd0);
    check_idle_done("rstbus", 1'b0, 1'b0, 1'b0);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h7777_7777;
    step();
    wb_ack_i = 1'b0;
    check_idle_done("rstbus late ack", 1'b0, 1'b0, 1'b0);
    check_output("rstbus data", dm_data_l_o, 32'h0);

    // Unacknowledged load: watchdog fires after 4 bus cycles, or waits forever.
    apply_stimulus(1'b1, 1'b0, 32'h0000_7000, 32'h0, 4'hF);
    step();
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    step();
    step();
    check_output("to cyc cycle4", 32'(wb_cyc_o), 32'd1);
`ifdef RV_DMEM_WB_TIMEOUT_EN
    step();
    check_idle_done("to expire", 1'b1, 1'b0, 1'b1);
    check_output("to data", dm_data_l_o, 32'hDEAD_BEEF);
`else
    for (int i = 0; i < 1000; i++) step();
    check_output("nto cyc", 32'(wb_cyc_o), 32'd1);
    check_output("nto stb", 32'(wb_stb_o), 32'd1);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h0BAD_F00D;
    step();
    wb_ack_i = 1'b0;
    check_idle_done("nto done", 1'b1, 1'b0, 1'b0);
    check_output("nto data", dm_data_l_o, 32'h0BAD_F00D);
`endif
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
